// File: rtl/lzc_stream.sv
// Streaming leading/trailing zero/one counter over multi-word packets, 2-stage pipeline.
// Define LZC_STREAM_SAT_EN to saturate the count (and report out_sat_o) instead of wrapping.
module lzc_stream #(
    parameter int N     = 8,
    parameter int GRP   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     in_data_i,
    input  logic [1:0]       in_mode_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_hit_o,
    output logic             out_sat_o
);
    localparam int WC_W = $clog2(N + 1);
    localparam int NG   = N / GRP;
    localparam int GC_W = $clog2(GRP + 1);
    localparam int SW   = CNT_W + 1;

    logic             first_q, first_d;
    logic [1:0]       mode_q, mode_d, mode_eff;
    logic             accept;
    logic [N-1:0]     scan_w;
    logic [NG-1:0]    gz;
    logic [NG-1:0][GC_W-1:0] gc;
    logic [WC_W-1:0]  wc;

    logic             s1_vld_q, s1_wh_q, s1_first_q, s1_last_q;
    logic [WC_W-1:0]  s1_wc_q;
    logic             s1_adv;

    logic [CNT_W-1:0] acc_q, acc_d, acc_nx, base_acc;
    logic             ph_q, ph_d, ph_nx, base_ph;
    logic             sat_q, sat_d, sat_nx, base_sat;
    logic [SW-1:0]    sum;

    logic             ovld_q, ohit_q, osat_q;
    logic [CNT_W-1:0] ocnt_q;

    assign accept   = in_valid_i && in_ready_o;
    assign mode_eff = first_q ? in_mode_i : mode_q;
    assign first_d  = accept ? in_last_i : first_q;
    assign mode_d   = (accept && first_q) ? in_mode_i : mode_q;

    // Normalise every mode to "count leading zeros": reverse for trailing, invert for ones.
    always_comb begin
        for (int i = 0; i < N; i++)
            scan_w[i] = mode_eff[0] ? in_data_i[N-1-i] : in_data_i[i];
        if (mode_eff[1]) scan_w = ~scan_w;
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [GRP-1:0]  bits;
        logic [GC_W-1:0] cnt;
        assign bits = scan_w[N-1-g*GRP -: GRP];
        always_comb begin
            cnt = GC_W'(GRP);
            for (int i = 0; i < GRP; i++)
                if (bits[i]) cnt = GC_W'(GRP - 1 - i);
        end
        assign gz[g] = ~|bits;
        assign gc[g] = cnt;
    end

    // Group 0 is the MSB group; the lowest-index non-empty group wins.
    always_comb begin
        wc = WC_W'(N);
        for (int g = NG - 1; g >= 0; g--)
            if (!gz[g]) wc = WC_W'(g * GRP) + WC_W'(gc[g]);
    end

    // A last beat may only retire when the output register is free or draining.
    assign s1_adv     = s1_vld_q && (!s1_last_q || !ovld_q || out_ready_i);
    assign in_ready_o = !s1_vld_q || s1_adv;

    always_comb begin
        base_acc = s1_first_q ? '0 : acc_q;
        base_ph  = s1_first_q ? 1'b0 : ph_q;
        base_sat = s1_first_q ? 1'b0 : sat_q;
        acc_nx   = base_acc;
        ph_nx    = base_ph;
        sat_nx   = base_sat;
        sum      = SW'(base_acc) + SW'(s1_wc_q);
        if (!base_ph) begin
            ph_nx  = s1_wh_q;
            acc_nx = sum[CNT_W-1:0];
`ifdef LZC_STREAM_SAT_EN
            if (sum[CNT_W]) begin
                acc_nx = '1;
                sat_nx = 1'b1;
            end
`endif
        end
        acc_d = acc_q;
        ph_d  = ph_q;
        sat_d = sat_q;
        if (s1_adv) begin
            acc_d = s1_last_q ? '0   : acc_nx;
            ph_d  = s1_last_q ? 1'b0 : ph_nx;
            sat_d = s1_last_q ? 1'b0 : sat_nx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_q    <= 1'b1;
            mode_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_wc_q    <= '0;
            s1_wh_q    <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            acc_q      <= '0;
            ph_q       <= 1'b0;
            sat_q      <= 1'b0;
            ovld_q     <= 1'b0;
            ocnt_q     <= '0;
            ohit_q     <= 1'b0;
            osat_q     <= 1'b0;
        end else begin
            first_q <= first_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            ph_q    <= ph_d;
            sat_q   <= sat_d;
            if (in_ready_o) s1_vld_q <= in_valid_i;
            if (accept) begin
                s1_wc_q    <= wc;
                s1_wh_q    <= (wc != WC_W'(N));
                s1_first_q <= first_q;
                s1_last_q  <= in_last_i;
            end
            if (s1_adv && s1_last_q) begin
                ovld_q <= 1'b1;
                ocnt_q <= acc_nx;
                ohit_q <= ph_nx;
                osat_q <= sat_nx;
            end else if (out_ready_i) begin
                ovld_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = ovld_q;
    assign out_count_o = ocnt_q;
    assign out_hit_o   = ohit_q;
    assign out_sat_o   = osat_q;
endmodule

// File: tb/tb_lzc_stream.sv
// Scoreboard bench for lzc_stream: directed packets push expected results, monitors pop on handshake.
module tb_lzc_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_last, out_valid, out_ready, out_hit, out_sat;
    logic [7:0] in_data, out_count;
    logic [1:0] in_mode;

    logic       d4_valid, d4_ready, d4_last, d4_ovalid, d4_hit, d4_sat;
    logic [7:0] d4_data;
    logic [3:0] d4_count;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic [5:0] q4[$];

    always #5 clk = ~clk;

    lzc_stream #(.N(8), .GRP(4), .CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_mode_i(in_mode), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_count_o(out_count),
        .out_hit_o(out_hit), .out_sat_o(out_sat));

    lzc_stream #(.N(8), .GRP(4), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(d4_valid), .in_ready_o(d4_ready),
        .in_data_i(d4_data), .in_mode_i(2'b00), .in_last_i(d4_last),
        .out_valid_o(d4_ovalid), .out_ready_i(1'b1), .out_count_o(d4_count),
        .out_hit_o(d4_hit), .out_sat_o(d4_sat));

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result: unexpected out count=%0d hit=%0b sat=%0b", out_count, out_hit, out_sat);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({out_count, out_hit, out_sat} !== e) begin
                    errors++;
                    $display("FAIL result: got count=%0d hit=%0b sat=%0b want count=%0d hit=%0b sat=%0b",
                             out_count, out_hit, out_sat, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d4_ovalid) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL result4: unexpected out count=%0d", d4_count);
            end else begin
                logic [5:0] e;
                e = q4.pop_front();
                if ({d4_count, d4_hit, d4_sat} !== e) begin
                    errors++;
                    $display("FAIL result4: got count=%0d hit=%0b sat=%0b want count=%0d hit=%0b sat=%0b",
                             d4_count, d4_hit, d4_sat, e[5:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic push(input logic [7:0] c, input logic h);
        exp_q.push_back({c, h, 1'b0});
    endtask

    // Caller is positioned just after a rising edge.
    task automatic beat(input logic [7:0] d, input logic [1:0] m, input logic l);
        int n;
        in_valid = 1'b1; in_data = d; in_mode = m; in_last = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept: in_ready=%0b want 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || q4.size() != 0) && n < 100) begin n++; @(negedge clk); end
        checks++;
        if (exp_q.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d/%0d want 0/0", exp_q.size(), q4.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outs(input string nm);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 8'd0 || out_hit !== 1'b0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL %s: rdy=%0b vld=%0b cnt=%0d hit=%0b sat=%0b want 1 0 0 0 0",
                     nm, in_ready, out_valid, out_count, out_hit, out_sat);
        end
    endtask

    initial begin
        logic saw_low;
        int   n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_last = 1'b0; out_ready = 1'b1;
        d4_valid = 1'b0; d4_data = '0; d4_last = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outs("reset_state");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single beat, latency check
        push(8'd2, 1'b1);
        beat(8'h28, 2'b00, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_t1: out_valid=%0b want 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_t2: out_valid=%0b want 1", out_valid); end
        @(posedge clk); #1;

        // Multi-word with idle gap mid-packet, then an early-hit packet
        push(8'd21, 1'b1);
        beat(8'h00, 2'b00, 1'b0);
        repeat (3) @(posedge clk); #1;
        beat(8'h00, 2'b00, 1'b0);
        beat(8'h05, 2'b00, 1'b1);
        push(8'd3, 1'b1);
        beat(8'h10, 2'b00, 1'b0);
        beat(8'h00, 2'b00, 1'b1);

        // Other modes; later-beat mode is ignored
        push(8'd15, 1'b1);
        beat(8'h00, 2'b01, 1'b0);
        beat(8'h80, 2'b00, 1'b1);
        push(8'd3, 1'b1);
        beat(8'hE0, 2'b10, 1'b1);
        push(8'd3, 1'b1);
        beat(8'h07, 2'b11, 1'b1);

        // No hit
        push(8'd32, 1'b0);
        for (int i = 0; i < 4; i++) beat(8'h00, 2'b00, i == 3);

        // Narrow count width overflow
`ifdef LZC_STREAM_SAT_EN
        q4.push_back({4'd15, 1'b0, 1'b1});
`else
        q4.push_back({4'd8, 1'b0, 1'b0});
`endif
        for (int i = 0; i < 3; i++) begin
            d4_valid = 1'b1; d4_data = 8'h00; d4_last = (i == 2);
            n = 0;
            @(negedge clk);
            while (!d4_ready && n < 50) begin n++; @(negedge clk); end
            @(posedge clk); #1;
        end
        d4_valid = 1'b0;
        drain();

        // Back-pressure
        out_ready = 1'b0;
        saw_low = 1'b0;
        fork
            begin
                push(8'd2, 1'b1); beat(8'h28, 2'b00, 1'b1);
                push(8'd7, 1'b1); beat(8'h01, 2'b00, 1'b1);
                push(8'd0, 1'b1); beat(8'h80, 2'b00, 1'b1);
                push(8'd4, 1'b1); beat(8'h0F, 2'b00, 1'b1);
            end
            begin
                int k;
                k = 0;
                @(negedge clk);
                while (!out_valid && k < 20) begin k++; @(negedge clk); end
                @(negedge clk);
                repeat (5) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_count !== 8'd2 || out_hit !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold: vld=%0b cnt=%0d hit=%0b want 1 2 1", out_valid, out_count, out_hit);
                    end
                    if (!in_ready) saw_low = 1'b1;
                    @(negedge clk);
                end
                checks++;
                if (!saw_low) begin errors++; $display("FAIL stall_ready: in_ready never 0, want 0"); end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-packet
        beat(8'h00, 2'b00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs("reset_mid");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push(8'd1, 1'b1);
        beat(8'h40, 2'b00, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
